// File: rtl/cnn_addr_pkg.sv
// cnn_addr_pkg: shared geometry, sizing helpers and scan states for the CNN address generators
package cnn_addr_pkg;
  localparam int MNIST_W = 28;
  localparam int C1_W = 24;
  localparam int P1_W = 12;
  localparam int C2_W = 8;
  localparam int P2_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} scan_state_t;
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/window_tap_counter.sv
// window_tap_counter: nested kc/kr/ch tap counter with wrap flags, shared with the weight readers
module window_tap_counter
  import cnn_addr_pkg::*;
#(
  parameter int K = 5,
  parameter int CH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  output logic [cnt_w(K)-1:0]    kc,
  output logic [cnt_w(K)-1:0]    kr,
  output logic [cnt_w(CH)-1:0]   ch,
  output logic                   col_wrap,
  output logic                   row_wrap,
  output logic                   win_wrap
);
  localparam int KW = cnt_w(K);
  localparam int CW = cnt_w(CH);
  localparam logic [KW-1:0] KM = KW'(K - 1);
  localparam logic [CW-1:0] CM = CW'(CH - 1);
  assign col_wrap = kc == KM;
  assign row_wrap = col_wrap && kr == KM;
  assign win_wrap = row_wrap && ch == CM;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {kc, kr, ch} <= '0;
    else if (clear) {kc, kr, ch} <= '0;
    else if (advance) begin
      kc <= col_wrap ? '0 : kc + 1'b1;
      if (col_wrap) kr <= row_wrap ? '0 : kr + 1'b1;
      if (row_wrap) ch <= win_wrap ? '0 : ch + 1'b1;
    end
  end
endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: multi-lane sliding-window tap address generator with start/busy/done handshake
module window_addr_gen
  import cnn_addr_pkg::*;
#(
  parameter int IMG_W = MNIST_W,
  parameter int IMG_H = MNIST_W,
  parameter int K = 5,
  parameter int STRIDE = 1,
  parameter int CH = 1,
  parameter int LANES = 4,
  parameter int LANE_ROWS = 6,
  parameter int BASE = 0,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ready,
  output logic [LANES*ADDR_W-1:0] addr,
  output logic                    valid,
  output logic                    win_last,
  output logic [ADDR_W-1:0]       out_idx,
  output logic                    busy,
  output logic                    done
);
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int PLANE = IMG_W * IMG_H;
  localparam int KW = cnt_w(K);
  localparam int CW = cnt_w(CH);
  localparam int XW = cnt_w(OUT_W);
  localparam int YW = cnt_w(LANE_ROWS);
  // distance from the last tap of a window back to its first tap
  localparam int BACK = (K - 1) * IMG_W + (K - 1) + (CH - 1) * PLANE;
  localparam logic [ADDR_W-1:0] D_COL = ADDR_W'(IMG_W - K + 1);
  localparam logic [ADDR_W-1:0] D_CH = ADDR_W'(PLANE - (K - 1) * IMG_W - (K - 1));
  localparam logic [ADDR_W-1:0] D_OX = ADDR_W'(STRIDE - BACK);
  localparam logic [ADDR_W-1:0] D_OY = ADDR_W'(STRIDE * IMG_W - (OUT_W - 1) * STRIDE - BACK);
  if ((IMG_W - K) % STRIDE != 0 || (IMG_H - K) % STRIDE != 0) begin : g_stride_err
    $error("window_addr_gen: stride does not tile the plane");
  end
  if (LANES * LANE_ROWS != OUT_H) begin : g_lane_err
    $error("window_addr_gen: LANES*LANE_ROWS must equal OUT_H");
  end
  if (longint'(BASE) + longint'(CH) * PLANE - 1 >= (longint'(1) << ADDR_W)) begin : g_width_err
    $error("window_addr_gen: address range exceeds ADDR_W");
  end
  scan_state_t state;
  logic [KW-1:0] kc, kr;
  logic [CW-1:0] ch;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [ADDR_W-1:0] acc [LANES];
  logic [ADDR_W-1:0] step;
  logic adv, col_wrap, row_wrap, win_wrap, ox_end, oy_end, final_beat;
  window_tap_counter #(.K(K), .CH(CH)) u_taps (
    .clk(clk), .reset(reset), .clear(state == IDLE), .advance(adv),
    .kc(kc), .kr(kr), .ch(ch),
    .col_wrap(col_wrap), .row_wrap(row_wrap), .win_wrap(win_wrap)
  );
  assign adv = valid && ready;
  assign ox_end = ox == XW'(OUT_W - 1);
  assign oy_end = oy == YW'(LANE_ROWS - 1);
  assign final_beat = win_wrap && ox_end && oy_end;
  assign win_last = valid && kc == KW'(K - 1) && kr == KW'(K - 1) && ch == CW'(CH - 1);
  assign step = !col_wrap ? ADDR_W'(1) : !row_wrap ? D_COL : !win_wrap ? D_CH : !ox_end ? D_OX : D_OY;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign addr[g*ADDR_W +: ADDR_W] = acc[g];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      {valid, busy, done} <= '0;
      ox <= '0;
      oy <= '0;
      out_idx <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          valid <= 1'b1;
          busy <= 1'b1;
          for (int l = 0; l < LANES; l++) acc[l] <= ADDR_W'(BASE + l * LANE_ROWS * STRIDE * IMG_W);
        end
        RUN: if (adv) begin
          if (win_wrap) begin
            ox <= ox_end ? '0 : ox + 1'b1;
            if (ox_end) oy <= oy_end ? '0 : oy + 1'b1;
            out_idx <= final_beat ? '0 : out_idx + 1'b1;
          end
          for (int l = 0; l < LANES; l++) acc[l] <= final_beat ? '0 : acc[l] + step;
          if (final_beat) begin
            state <= DONE;
            valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: checks three geometries against an index-decomposition address model
module tb_window_addr_gen;
  localparam int D_BEATS = 3600;
  localparam int P_BEATS = 576;
  localparam int C_BEATS = 3200;
  logic clk = 0;
  logic reset = 1;
  logic d_start = 0, d_ready = 1, d_valid, d_last, d_busy, d_done;
  logic [39:0] d_addr;
  logic [9:0] d_idx;
  logic p_start = 0, p_ready = 1, p_valid, p_last, p_busy, p_done;
  logic [9:0] p_addr, p_idx;
  logic c_start = 0, c_ready = 1, c_valid, c_last, c_busy, c_done;
  logic [9:0] c_addr, c_idx;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  window_addr_gen u_d (
    .clk(clk), .reset(reset), .start(d_start), .ready(d_ready), .addr(d_addr), .valid(d_valid),
    .win_last(d_last), .out_idx(d_idx), .busy(d_busy), .done(d_done)
  );
  window_addr_gen #(.IMG_W(24), .IMG_H(24), .K(2), .STRIDE(2), .LANES(1), .LANE_ROWS(12)) u_p (
    .clk(clk), .reset(reset), .start(p_start), .ready(p_ready), .addr(p_addr), .valid(p_valid),
    .win_last(p_last), .out_idx(p_idx), .busy(p_busy), .done(p_done)
  );
  window_addr_gen #(.IMG_W(12), .IMG_H(12), .K(5), .CH(2), .LANES(1), .LANE_ROWS(8)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .ready(c_ready), .addr(c_addr), .valid(c_valid),
    .win_last(c_last), .out_idx(c_idx), .busy(c_busy), .done(c_done)
  );
  // beat n decomposed innermost-first into kc, kr, ch, ox, oy
  function automatic int ref_addr(input int n, input int l, input int w, input int h, input int k,
                                  input int s, input int nch, input int lr);
    int m, kc, kr, c, ow, ox, oy;
    m = n;
    kc = m % k; m = m / k;
    kr = m % k; m = m / k;
    c = m % nch; m = m / nch;
    ow = (w - k) / s + 1;
    ox = m % ow;
    oy = m / ow;
    return c * w * h + ((oy + l * lr) * s + kr) * w + ox * s + kc;
  endfunction
  function automatic int ref_idx(input int n, input int k, input int nch);
    return n / (k * k * nch);
  endfunction
  function automatic bit ref_last(input int n, input int k, input int nch);
    return (n % (k * k * nch)) == k * k * nch - 1;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick();
    checks++;
    if (d_addr !== 40'd0 || d_valid !== 1'b0 || d_last !== 1'b0 || d_idx !== 10'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state addr=%h valid=%b last=%b idx=%0d busy=%b done=%b want all 0", d_addr, d_valid, d_last, d_idx, d_busy, d_done);
    end
    reset = 0;
    tick();
    checks++;
    if (d_valid !== 1'b0 || d_busy !== 1'b0 || p_valid !== 1'b0 || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset d_valid=%b d_busy=%b p_valid=%b c_valid=%b want 0", d_valid, d_busy, p_valid, c_valid);
    end
  endtask
  task automatic test_default_scan;
    int n, cyc, early, want;
    int b0[4] = '{0, 168, 336, 504};
    n = 0; cyc = 0; early = 0;
    d_ready = 1; d_start = 1; tick(); d_start = 0;
    checks++;
    if (d_valid !== 1'b1 || d_busy !== 1'b1) begin
      errors++;
      $display("FAIL dflt_latency valid=%b busy=%b want 1 1", d_valid, d_busy);
    end
    while (n < D_BEATS && cyc < D_BEATS + 50) begin
      if (d_valid) begin
        for (int l = 0; l < 4; l++) begin
          checks++;
          if (d_addr[l*10 +: 10] !== 10'(ref_addr(n, l, 28, 28, 5, 1, 1, 6))) begin
            errors++;
            $display("FAIL dflt_addr beat=%0d lane=%0d got=%0d want=%0d", n, l, d_addr[l*10 +: 10], ref_addr(n, l, 28, 28, 5, 1, 1, 6));
          end
          if (n == 0) begin
            checks++;
            if (d_addr[l*10 +: 10] !== 10'(b0[l])) begin
              errors++;
              $display("FAIL dflt_beat0 lane=%0d got=%0d want=%0d", l, d_addr[l*10 +: 10], b0[l]);
            end
          end
        end
        if (n == 5 || n == 24 || n == 25) begin
          want = n == 5 ? 28 : n == 24 ? 116 : 1;
          checks++;
          if (d_addr[9:0] !== 10'(want) || d_last !== (n == 24) || d_idx !== 10'(n == 25 ? 1 : 0)) begin
            errors++;
            $display("FAIL dflt_spot beat=%0d lane0=%0d last=%b idx=%0d want %0d %b %0d", n, d_addr[9:0], d_last, d_idx, want, n == 24, n == 25 ? 1 : 0);
          end
        end
        checks++;
        if (d_last !== ref_last(n, 5, 1) || d_idx !== 10'(ref_idx(n, 5, 1))) begin
          errors++;
          $display("FAIL dflt_last_idx beat=%0d last=%b idx=%0d want %b %0d", n, d_last, d_idx, ref_last(n, 5, 1), ref_idx(n, 5, 1));
        end
        n++;
      end
      if (d_done) early++;
      tick(); cyc++;
    end
    checks++;
    if (n != D_BEATS || early != 0) begin
      errors++;
      $display("FAIL dflt_count beats=%0d early_done=%0d want %0d 0", n, early, D_BEATS);
    end
    checks++;
    if (d_done !== 1'b1 || d_valid !== 1'b0 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL dflt_done done=%b valid=%b busy=%b want 1 0 0", d_done, d_valid, d_busy);
    end
    tick();
    checks++;
    if (d_done !== 1'b0 || d_valid !== 1'b0 || d_addr !== 40'd0) begin
      errors++;
      $display("FAIL dflt_after_done done=%b valid=%b addr=%h want 0 0 0", d_done, d_valid, d_addr);
    end
  endtask
  task automatic test_stall;
    int n, cyc, dones;
    bit stalled;
    n = 0; cyc = 0; dones = 0; stalled = 0;
    d_ready = 1; d_start = 1; tick(); d_start = 0;
    while (n < D_BEATS && cyc < D_BEATS * 8) begin
      if (d_valid) begin
        if (n == 7 && !stalled) begin
          d_ready = 0;
          repeat (3) begin
            tick(); cyc++;
            checks++;
            if (d_valid !== 1'b1 || d_addr[9:0] !== 10'(ref_addr(7, 0, 28, 28, 5, 1, 1, 6)) || d_addr[39:30] !== 10'(ref_addr(7, 3, 28, 28, 5, 1, 1, 6)) || d_last !== 1'b0 || d_idx !== 10'd0) begin
              errors++;
              $display("FAIL stall_hold valid=%b lane0=%0d lane3=%0d last=%b idx=%0d want 1 %0d %0d 0 0", d_valid, d_addr[9:0], d_addr[39:30], d_last, d_idx, ref_addr(7, 0, 28, 28, 5, 1, 1, 6), ref_addr(7, 3, 28, 28, 5, 1, 1, 6));
            end
          end
          stalled = 1;
        end
        for (int l = 0; l < 4; l++) begin
          checks++;
          if (d_addr[l*10 +: 10] !== 10'(ref_addr(n, l, 28, 28, 5, 1, 1, 6))) begin
            errors++;
            $display("FAIL stall_addr beat=%0d lane=%0d got=%0d want=%0d", n, l, d_addr[l*10 +: 10], ref_addr(n, l, 28, 28, 5, 1, 1, 6));
          end
        end
        checks++;
        if (d_last !== ref_last(n, 5, 1) || d_idx !== 10'(ref_idx(n, 5, 1))) begin
          errors++;
          $display("FAIL stall_last_idx beat=%0d last=%b idx=%0d want %b %0d", n, d_last, d_idx, ref_last(n, 5, 1), ref_idx(n, 5, 1));
        end
        d_ready = n < 8 ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (d_ready) n++;
      end
      if (d_done) dones++;
      tick(); cyc++;
    end
    d_ready = 1;
    if (d_done) dones++;
    tick();
    checks++;
    if (n != D_BEATS || dones != 1 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_count beats=%0d dones=%0d busy=%b want %0d 1 0", n, dones, d_busy, D_BEATS);
    end
  endtask
  task automatic test_pool;
    int n, cyc, dones;
    int ps[8] = '{0, 1, 24, 25, 2, 3, 26, 27};
    n = 0; cyc = 0; dones = 0;
    p_ready = 1; p_start = 1; tick(); p_start = 0;
    while (n < P_BEATS && cyc < P_BEATS + 50) begin
      if (p_valid) begin
        checks++;
        if (p_addr !== 10'(ref_addr(n, 0, 24, 24, 2, 2, 1, 12)) || p_last !== ref_last(n, 2, 1) || p_idx !== 10'(ref_idx(n, 2, 1))) begin
          errors++;
          $display("FAIL pool_beat beat=%0d addr=%0d last=%b idx=%0d want %0d %b %0d", n, p_addr, p_last, p_idx, ref_addr(n, 0, 24, 24, 2, 2, 1, 12), ref_last(n, 2, 1), ref_idx(n, 2, 1));
        end
        if (n < 8 || n == 48) begin
          checks++;
          if (p_addr !== 10'(n == 48 ? 48 : ps[n % 8])) begin
            errors++;
            $display("FAIL pool_spot beat=%0d got=%0d want=%0d", n, p_addr, n == 48 ? 48 : ps[n % 8]);
          end
        end
        n++;
      end
      if (p_done) dones++;
      tick(); cyc++;
    end
    checks++;
    if (n != P_BEATS || dones != 0 || p_done !== 1'b1 || p_valid !== 1'b0) begin
      errors++;
      $display("FAIL pool_end beats=%0d early=%0d done=%b valid=%b want %0d 0 1 0", n, dones, p_done, p_valid, P_BEATS);
    end
    tick();
  endtask
  task automatic test_channels;
    int n, cyc, dones, want;
    n = 0; cyc = 0; dones = 0;
    c_start = 1; tick(); c_start = 0;
    while (n < C_BEATS && cyc < C_BEATS * 8) begin
      if (c_valid) begin
        checks++;
        if (c_addr !== 10'(ref_addr(n, 0, 12, 12, 5, 1, 2, 8)) || c_last !== ref_last(n, 5, 2) || c_idx !== 10'(ref_idx(n, 5, 2))) begin
          errors++;
          $display("FAIL chan_beat beat=%0d addr=%0d last=%b idx=%0d want %0d %b %0d", n, c_addr, c_last, c_idx, ref_addr(n, 0, 12, 12, 5, 1, 2, 8), ref_last(n, 5, 2), ref_idx(n, 5, 2));
        end
        if (n == 24 || n == 25 || n == 49 || n == 50) begin
          want = n == 24 ? 52 : n == 25 ? 144 : n == 49 ? 196 : 1;
          checks++;
          if (c_addr !== 10'(want) || c_last !== (n == 49)) begin
            errors++;
            $display("FAIL chan_spot beat=%0d got=%0d last=%b want %0d %b", n, c_addr, c_last, want, n == 49);
          end
        end
        c_ready = $urandom_range(0, 4) != 0;
        if (c_ready) n++;
      end
      if (c_done) dones++;
      tick(); cyc++;
    end
    c_ready = 1;
    checks++;
    if (n != C_BEATS || dones != 0 || c_done !== 1'b1) begin
      errors++;
      $display("FAIL chan_end beats=%0d early=%0d done=%b want %0d 0 1", n, dones, c_done, C_BEATS);
    end
    tick();
  endtask
  task automatic test_start_ignored;
    int n, cyc, dones;
    n = 0; cyc = 0; dones = 0;
    d_ready = 1; d_start = 1; tick(); d_start = 0;
    while (n < D_BEATS && cyc < D_BEATS + 50) begin
      if (d_valid) begin
        checks++;
        if (d_addr[9:0] !== 10'(ref_addr(n, 0, 28, 28, 5, 1, 1, 6))) begin
          errors++;
          $display("FAIL restart_addr beat=%0d got=%0d want=%0d", n, d_addr[9:0], ref_addr(n, 0, 28, 28, 5, 1, 1, 6));
        end
        if (n == 1000) d_start = 1;
        n++;
      end
      if (d_done) dones++;
      tick(); cyc++;
      d_start = 0;
    end
    checks++;
    if (n != D_BEATS || d_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_count beats=%0d done=%b want %0d 1", n, d_done, D_BEATS);
    end
    dones++;
    d_start = 1; tick(); d_start = 0;
    repeat (4) begin
      if (d_done) dones++;
      checks++;
      if (d_valid !== 1'b0 || d_busy !== 1'b0) begin
        errors++;
        $display("FAIL restart_in_done valid=%b busy=%b want 0 0", d_valid, d_busy);
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL restart_dones got=%0d want=1", dones);
    end
  endtask
  task automatic test_reset_mid;
    int n, cyc, dones;
    n = 0; cyc = 0; dones = 0;
    d_ready = 1; d_start = 1; tick(); d_start = 0;
    while (n < 100 && cyc < 200) begin
      if (d_valid) n++;
      tick(); cyc++;
    end
    checks++;
    if (d_valid !== 1'b1 || d_addr[9:0] !== 10'(ref_addr(100, 0, 28, 28, 5, 1, 1, 6))) begin
      errors++;
      $display("FAIL midrst_pre valid=%b lane0=%0d want 1 %0d", d_valid, d_addr[9:0], ref_addr(100, 0, 28, 28, 5, 1, 1, 6));
    end
    reset = 1;
    #1;
    checks++;
    if (d_addr !== 40'd0 || d_valid !== 1'b0 || d_last !== 1'b0 || d_idx !== 10'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear addr=%h valid=%b last=%b idx=%0d busy=%b done=%b want all 0", d_addr, d_valid, d_last, d_idx, d_busy, d_done);
    end
    tick();
    reset = 0;
    repeat (4) begin
      if (d_done || d_valid) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrst_quiet done_or_valid_cycles=%0d want 0", dones);
    end
    d_start = 1; tick(); d_start = 0;
    checks++;
    if (d_valid !== 1'b1 || d_addr[9:0] !== 10'd0 || d_addr[19:10] !== 10'd168 || d_idx !== 10'd0) begin
      errors++;
      $display("FAIL midrst_restart valid=%b lane0=%0d lane1=%0d idx=%0d want 1 0 168 0", d_valid, d_addr[9:0], d_addr[19:10], d_idx);
    end
    reset = 1; tick(); reset = 0; tick();
  endtask
  initial begin
    test_reset();
    test_default_scan();
    test_stall();
    test_pool();
    test_channels();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
